icb_arbt_rr: RTL and testbench
==============================

Name: icb_arbt_rr

Overview:
- N-to-1 ICB command arbiter with a selectable scheme: fixed priority or round-robin.
- Holds the grant on a stalled command and tracks outstanding transactions in an internal ID FIFO, so responses are routed back to the issuing port in order.
- Sits between several ICB masters (cores, DMA, debug) and one shared ICB slave or bus segment.
- Successor to the fixed-priority one-hot arbiter: adds round-robin fairness, grant stability, encoded IDs and an outstanding count.

Parameters:
- AW, 32, address width.
- DW, 64, data width; wmask width is DW/8.
- USR_W, 1, user sideband width; passed on cmd, returned on rsp.
- ARBT_NUM, 4, number of upstream ports; legal range 2..16.
- ARBT_SCHEME, 1, arbitration scheme: 0 = fixed priority (lowest index wins), 1 = round-robin.
- FIFO_DP, 2, maximum outstanding transactions; must be >=1.
- ALLOW_0CYCL_RSP, 1, 1 = a response in the same cycle as its command handshake is accepted via bypass.
- ID_W, derived, clog2(ARBT_NUM); localparam, not overridable.
- CNT_W, derived, clog2(FIFO_DP+1); localparam, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- i_bus_icb_cmd_vld  in  ARBT_NUM  per-port command valid.
- i_bus_icb_cmd_rdy  out  ARBT_NUM  per-port command ready.
- i_bus_icb_cmd_read  in  ARBT_NUM  per-port read flag.
- i_bus_icb_cmd_addr  in  ARBT_NUM*AW  packed addresses; port i at [i*AW +: AW].
- i_bus_icb_cmd_wdata  in  ARBT_NUM*DW  packed write data.
- i_bus_icb_cmd_wmask  in  ARBT_NUM*DW/8  packed write masks.
- i_bus_icb_cmd_usr  in  ARBT_NUM*USR_W  packed user bits.
- i_bus_icb_rsp_vld  out  ARBT_NUM  per-port response valid.
- i_bus_icb_rsp_rdy  in  ARBT_NUM  per-port response ready.
- i_bus_icb_rsp_err  out  ARBT_NUM  response error, broadcast to all ports.
- i_bus_icb_rsp_rdata  out  ARBT_NUM*DW  response read data, broadcast.
- i_bus_icb_rsp_usr  out  ARBT_NUM*USR_W  response user bits, broadcast.
- o_icb_cmd_vld / o_icb_cmd_rdy  out / in  1  downstream command handshake.
- o_icb_cmd_read / addr / wdata / wmask / usr  out  1 / AW / DW / DW/8 / USR_W  muxed command fields of the granted port.
- o_icb_rsp_vld / o_icb_rsp_rdy  in / out  1  downstream response handshake.
- o_icb_rsp_err / rdata / usr  in  1 / DW / USR_W  downstream response fields.
- o_grant_id  out  ID_W  currently granted port; valid when o_icb_cmd_vld=1.
- o_outstanding  out  CNT_W  number of entries in the ID FIFO.

Behaviour:
- Reset (rst=0, async): rr_ptr = ARBT_NUM-1, so port 0 has first priority; lock=0; FIFO empty; o_outstanding=0. All vld/rdy outputs are 0 while inputs are idle.
- Candidate selection, lock=0:
  - Scheme 0: lowest-index valid port.
  - Scheme 1: first valid port searching from (rr_ptr+1) mod ARBT_NUM upward with wrap.
  - No valid port: nothing selected; o_grant_id=0.
- Grant lock:
  - If o_icb_cmd_vld=1 and o_icb_cmd_rdy=0, register lock=1 and lock_id=grant.
  - While lock=1 the grant is lock_id regardless of other requests.
  - lock clears on the handshake cycle.
  - Upstream must hold vld and fields stable once asserted; the arbiter does not check this.
- Command path:
  - o_icb_cmd_vld = selected vld & ~fifo_full.
  - i_bus_icb_cmd_rdy[g] = o_icb_cmd_rdy & ~fifo_full; all other ports get 0.
  - Data fields are muxed by the grant; zero when nothing is selected.
- rr_ptr updates to the granted index on command handshake only (scheme 1); it is unused in scheme 0.
- FIFO full blocks commands combinationally from registered full. A pop in the same cycle does not free the slot: no rdy->rdy path, one bubble.
- Push: on cmd handshake, push grant ID, unless bypass.
- Pop: on rsp handshake, pop, unless bypass.
- Push and pop in the same cycle: o_outstanding unchanged.
- Response routing:
  - FIFO non-empty: target = FIFO head ID.
  - FIFO empty and ALLOW_0CYCL_RSP=1: target = current grant. Bypass applies when cmd and rsp handshakes occur in the same cycle; no FIFO write or read.
  - FIFO empty and ALLOW_0CYCL_RSP=0: i_bus_icb_rsp_vld=0 and o_icb_rsp_rdy=0.
  - i_bus_icb_rsp_vld[t] = o_icb_rsp_vld (gated as above); o_icb_rsp_rdy = i_bus_icb_rsp_rdy[t].
- Response ordering is strictly in order, one response per command, write commands included.
- A response arriving while the FIFO is empty without bypass is a protocol error. It is not accepted (rdy=0).

Test Plan:
- Scheme 1, ports 0..3 all valid, o_icb_cmd_rdy=1 continuously -> grants 0,1,2,3,0; o_grant_id increments each cycle.
- Scheme 0, ports 1 and 3 valid -> port 1 wins every cycle; port 3 starves until port 1 drops vld.
- Port 2 granted with o_icb_cmd_rdy=0 for 3 cycles, port 0 raises vld in cycle 2 -> grant stays 2 until handshake; next grant is port 0 (scheme 0) or port 3 (scheme 1, if valid).
- FIFO_DP=2, two commands accepted, no responses -> o_outstanding=2, o_icb_cmd_vld=0, all cmd_rdy=0. A response to port of first command pops it; commands resume next cycle with o_outstanding back to 2 after the next push.
- ALLOW_0CYCL_RSP=1, FIFO empty, port 1 cmd and rsp handshake in the same cycle -> i_bus_icb_rsp_vld=4'b0010, o_outstanding stays 0.
- Two commands outstanding, rst pulsed low mid-transfer -> o_outstanding=0, lock=0 immediately (async). First post-reset round-robin grant goes to port 0.

Source files
------------

// File: rtl/icb_arbt_rr.sv
// N-to-1 ICB command arbiter with fixed-priority or round-robin selection.
// A stalled command keeps its grant until it handshakes. The port ID of every
// accepted command is queued in an ID FIFO so responses return, in order, to
// the port that issued them. With ALLOW_0CYCL_RSP a response that handshakes in
// the same cycle as its command bypasses the FIFO.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_bus_icb_cmd_*          upstream command channels (packed, port i at [i*W +: W])
//   i_bus_icb_rsp_*          upstream response channels (data fields broadcast)
//   o_icb_cmd_*              downstream command channel (granted port's fields)
//   o_icb_rsp_*              downstream response channel
//   o_grant_id               currently granted port, 0 when nothing is selected
//   o_outstanding            number of entries in the ID FIFO
module icb_arbt_rr #(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 64,
  parameter int unsigned USR_W           = 1,
  parameter int unsigned ARBT_NUM        = 4,
  parameter int unsigned ARBT_SCHEME     = 1,
  parameter int unsigned FIFO_DP         = 2,
  parameter int unsigned ALLOW_0CYCL_RSP = 1,
  localparam int unsigned ID_W           = $clog2(ARBT_NUM),
  localparam int unsigned CNT_W          = $clog2(FIFO_DP + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ARBT_NUM-1:0]       i_bus_icb_cmd_vld,
  output logic [ARBT_NUM-1:0]       i_bus_icb_cmd_rdy,
  input  logic [ARBT_NUM-1:0]       i_bus_icb_cmd_read,
  input  logic [ARBT_NUM*AW-1:0]    i_bus_icb_cmd_addr,
  input  logic [ARBT_NUM*DW-1:0]    i_bus_icb_cmd_wdata,
  input  logic [ARBT_NUM*DW/8-1:0]  i_bus_icb_cmd_wmask,
  input  logic [ARBT_NUM*USR_W-1:0] i_bus_icb_cmd_usr,
  output logic [ARBT_NUM-1:0]       i_bus_icb_rsp_vld,
  input  logic [ARBT_NUM-1:0]       i_bus_icb_rsp_rdy,
  output logic [ARBT_NUM-1:0]       i_bus_icb_rsp_err,
  output logic [ARBT_NUM*DW-1:0]    i_bus_icb_rsp_rdata,
  output logic [ARBT_NUM*USR_W-1:0] i_bus_icb_rsp_usr,
  output logic                      o_icb_cmd_vld,
  input  logic                      o_icb_cmd_rdy,
  output logic                      o_icb_cmd_read,
  output logic [AW-1:0]             o_icb_cmd_addr,
  output logic [DW-1:0]             o_icb_cmd_wdata,
  output logic [DW/8-1:0]           o_icb_cmd_wmask,
  output logic [USR_W-1:0]          o_icb_cmd_usr,
  input  logic                      o_icb_rsp_vld,
  output logic                      o_icb_rsp_rdy,
  input  logic                      o_icb_rsp_err,
  input  logic [DW-1:0]             o_icb_rsp_rdata,
  input  logic [USR_W-1:0]          o_icb_rsp_usr,
  output logic [ID_W-1:0]           o_grant_id,
  output logic [CNT_W-1:0]          o_outstanding
);

  localparam int unsigned PTR_W = (FIFO_DP > 1) ? $clog2(FIFO_DP) : 1;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic [ID_W-1:0]  fifo_q [FIFO_DP];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic            sel_vld;
  logic [ID_W-1:0] sel_id, grant;
  logic            fifo_full, fifo_empty;
  logic            cmd_hsk, rsp_hsk, rsp_en, bypass, push, pop;
  logic [ID_W-1:0] rsp_tgt;

  // Candidate selection; a locked grant overrides any new request.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    if (lock_q) begin
      sel_id  = lock_id_q;
      sel_vld = i_bus_icb_cmd_vld[lock_id_q];
    end else if (ARBT_SCHEME == 0) begin
      for (int i = ARBT_NUM - 1; i >= 0; i--) begin
        if (i_bus_icb_cmd_vld[i]) begin
          sel_vld = 1'b1;
          sel_id  = ID_W'(i);
        end
      end
    end else begin
      // Walk from farthest to nearest so the port just after rr_ptr wins.
      for (int k = ARBT_NUM; k >= 1; k--) begin
        if (i_bus_icb_cmd_vld[(int'(rr_ptr_q) + k) % ARBT_NUM]) begin
          sel_vld = 1'b1;
          sel_id  = ID_W'((int'(rr_ptr_q) + k) % ARBT_NUM);
        end
      end
    end
  end

  assign grant      = sel_vld ? sel_id : '0;
  assign o_grant_id = grant;

  // Full is taken from the registered count, so a same-cycle pop cannot
  // reopen the command path (no rsp_rdy -> cmd_rdy combinational path).
  assign fifo_full     = (cnt_q == CNT_W'(FIFO_DP));
  assign fifo_empty    = (cnt_q == '0);
  assign o_outstanding = cnt_q;

  assign o_icb_cmd_vld   = sel_vld & ~fifo_full;
  assign cmd_hsk         = o_icb_cmd_vld & o_icb_cmd_rdy;
  assign o_icb_cmd_read  = sel_vld ? i_bus_icb_cmd_read[grant] : 1'b0;
  assign o_icb_cmd_addr  = sel_vld ? i_bus_icb_cmd_addr[grant*AW +: AW] : '0;
  assign o_icb_cmd_wdata = sel_vld ? i_bus_icb_cmd_wdata[grant*DW +: DW] : '0;
  assign o_icb_cmd_wmask = sel_vld ? i_bus_icb_cmd_wmask[grant*(DW/8) +: DW/8] : '0;
  assign o_icb_cmd_usr   = sel_vld ? i_bus_icb_cmd_usr[grant*USR_W +: USR_W] : '0;

  always_comb begin
    i_bus_icb_cmd_rdy = '0;
    for (int i = 0; i < ARBT_NUM; i++) begin
      if (sel_vld && (grant == ID_W'(i))) begin
        i_bus_icb_cmd_rdy[i] = o_icb_cmd_rdy & ~fifo_full;
      end
    end
  end

  // Response routing: FIFO head when something is outstanding, otherwise only
  // the zero-cycle bypass of a command handshaking right now may respond.
  always_comb begin
    if (!fifo_empty) begin
      rsp_en  = 1'b1;
      rsp_tgt = fifo_q[rd_ptr_q];
    end else begin
      rsp_en  = (ALLOW_0CYCL_RSP != 0) && cmd_hsk;
      rsp_tgt = grant;
    end
  end

  always_comb begin
    i_bus_icb_rsp_vld = '0;
    for (int i = 0; i < ARBT_NUM; i++) begin
      if (rsp_en && (rsp_tgt == ID_W'(i))) begin
        i_bus_icb_rsp_vld[i] = o_icb_rsp_vld;
      end
    end
  end

  assign o_icb_rsp_rdy       = rsp_en & i_bus_icb_rsp_rdy[rsp_tgt];
  assign rsp_hsk             = o_icb_rsp_vld & o_icb_rsp_rdy;
  assign i_bus_icb_rsp_err   = {ARBT_NUM{o_icb_rsp_err}};
  assign i_bus_icb_rsp_rdata = {ARBT_NUM{o_icb_rsp_rdata}};
  assign i_bus_icb_rsp_usr   = {ARBT_NUM{o_icb_rsp_usr}};

  assign bypass = fifo_empty & cmd_hsk & rsp_hsk;
  assign push   = cmd_hsk & ~bypass;
  assign pop    = rsp_hsk & ~bypass;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (o_icb_cmd_vld && !o_icb_cmd_rdy) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end else if (cmd_hsk) begin
      lock_d = 1'b0;
    end
    if (cmd_hsk) begin
      rr_ptr_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= ID_W'(ARBT_NUM - 1);
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DP; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= grant;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DP - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DP - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icb_arbt_rr.sv
// Bench for icb_arbt_rr: one fixed-priority and one round-robin instance share
// the same stimulus; each is compared every cycle against a queue-based model.
module tb_icb_arbt_rr;

  localparam int N = 4;

  logic clk, rst;
  logic [3:0]   c_vld, c_read, c_usr, c_rrdy;
  logic [127:0] c_addr;
  logic [255:0] c_wdata;
  logic [31:0]  c_wmask;
  logic         c_crdy, c_rvld, c_rerr, c_rusr;
  logic [63:0]  c_rdata;

  logic [3:0]   d_cmd_rdy [2];
  logic [3:0]   d_rsp_vld [2];
  logic [3:0]   d_rsp_err [2];
  logic [3:0]   d_rsp_usr [2];
  logic [255:0] d_rdata   [2];
  logic         d_cvld    [2];
  logic         d_read    [2];
  logic         d_usr     [2];
  logic         d_rrdy    [2];
  logic [31:0]  d_addr    [2];
  logic [63:0]  d_wdata   [2];
  logic [7:0]   d_wmask   [2];
  logic [1:0]   d_gnt     [2];
  logic [1:0]   d_out     [2];

  for (genvar s = 0; s < 2; s++) begin : g_dut
    icb_arbt_rr #(.ARBT_SCHEME(s)) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_bus_icb_cmd_vld   (c_vld),
      .i_bus_icb_cmd_rdy   (d_cmd_rdy[s]),
      .i_bus_icb_cmd_read  (c_read),
      .i_bus_icb_cmd_addr  (c_addr),
      .i_bus_icb_cmd_wdata (c_wdata),
      .i_bus_icb_cmd_wmask (c_wmask),
      .i_bus_icb_cmd_usr   (c_usr),
      .i_bus_icb_rsp_vld   (d_rsp_vld[s]),
      .i_bus_icb_rsp_rdy   (c_rrdy),
      .i_bus_icb_rsp_err   (d_rsp_err[s]),
      .i_bus_icb_rsp_rdata (d_rdata[s]),
      .i_bus_icb_rsp_usr   (d_rsp_usr[s]),
      .o_icb_cmd_vld       (d_cvld[s]),
      .o_icb_cmd_rdy       (c_crdy),
      .o_icb_cmd_read      (d_read[s]),
      .o_icb_cmd_addr      (d_addr[s]),
      .o_icb_cmd_wdata     (d_wdata[s]),
      .o_icb_cmd_wmask     (d_wmask[s]),
      .o_icb_cmd_usr       (d_usr[s]),
      .o_icb_rsp_vld       (c_rvld),
      .o_icb_rsp_rdy       (d_rrdy[s]),
      .o_icb_rsp_err       (c_rerr),
      .o_icb_rsp_rdata     (c_rdata),
      .o_icb_rsp_usr       (c_rusr),
      .o_grant_id          (d_gnt[s]),
      .o_outstanding       (d_out[s])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: s=0 fixed priority, s=1 round-robin.
  bit m_lock [2];
  int m_lid  [2];
  int m_ptr  [2];
  int m_q    [2][$];
  // Per-cycle model results kept for the state update at the clock edge.
  bit e_cvld [2];
  bit e_chsk [2];
  bit e_rhsk [2];
  bit e_empty[2];
  int e_id   [2];
  bit pend   [4];

  task automatic chk(input int s, input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", (s == 1) ? "rr" : "fp", nm, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int s = 0; s < 2; s++) begin
      m_lock[s] = 1'b0;
      m_lid[s]  = 0;
      m_ptr[s]  = N - 1;
      m_q[s].delete();
    end
  endtask

  // Wait for the falling edge, predict every output from the model and compare.
  task automatic eval();
    logic [3:0] one;
    one = 4'b0001;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      bit v, full, en, rsp_rdy_x;
      int id, gnt, tgt;
      v  = 1'b0;
      id = 0;
      if (m_lock[s]) begin
        id = m_lid[s];
        v  = c_vld[id];
      end else begin
        for (int k = 0; k < N; k++) begin
          int p;
          p = (s == 0) ? k : (m_ptr[s] + 1 + k) % N;
          if (!v && c_vld[p]) begin
            v  = 1'b1;
            id = p;
          end
        end
      end
      full       = (m_q[s].size() >= 2);
      gnt        = v ? id : 0;
      e_id[s]    = gnt;
      e_cvld[s]  = v && !full;
      e_chsk[s]  = e_cvld[s] && c_crdy;
      e_empty[s] = (m_q[s].size() == 0);
      en         = !e_empty[s] || e_chsk[s];
      tgt        = e_empty[s] ? gnt : m_q[s][0];
      rsp_rdy_x  = en && c_rrdy[tgt];
      e_rhsk[s]  = c_rvld && rsp_rdy_x;

      chk(s, "grant", 64'(d_gnt[s]), 64'(gnt));
      chk(s, "cmd_vld", 64'(d_cvld[s]), 64'(e_cvld[s]));
      chk(s, "cmd_rdy", 64'(d_cmd_rdy[s]), e_chsk[s] ? 64'(one << id) : 64'd0);
      chk(s, "outstanding", 64'(d_out[s]), 64'(m_q[s].size()));
      chk(s, "rsp_vld", 64'(d_rsp_vld[s]), (en && c_rvld) ? 64'(one << tgt) : 64'd0);
      chk(s, "rsp_rdy", 64'(d_rrdy[s]), 64'(rsp_rdy_x));
      chk(s, "addr", 64'(d_addr[s]), v ? 64'(c_addr[id*32 +: 32]) : 64'd0);
      chk(s, "read", 64'(d_read[s]), v ? 64'(c_read[id]) : 64'd0);
      chk(s, "wdata", d_wdata[s], v ? c_wdata[id*64 +: 64] : 64'd0);
      chk(s, "wmask", 64'(d_wmask[s]), v ? 64'(c_wmask[id*8 +: 8]) : 64'd0);
      chk(s, "usr", 64'(d_usr[s]), v ? 64'(c_usr[id]) : 64'd0);
      chk(s, "rsp_err", 64'(d_rsp_err[s]), c_rerr ? 64'hF : 64'h0);
      chk(s, "rsp_usr", 64'(d_rsp_usr[s]), c_rusr ? 64'hF : 64'h0);
      chk(s, "rsp_rdata_lane0", d_rdata[s][63:0], c_rdata);
      chk(s, "rsp_rdata_lane3", d_rdata[s][255:192], c_rdata);
    end
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      if (!(e_empty[s] && e_chsk[s] && e_rhsk[s])) begin
        if (e_rhsk[s]) void'(m_q[s].pop_front());
        if (e_chsk[s]) m_q[s].push_back(e_id[s]);
      end
      if (e_cvld[s] && !c_crdy) begin
        m_lock[s] = 1'b1;
        m_lid[s]  = e_id[s];
      end else if (e_chsk[s]) begin
        m_lock[s] = 1'b0;
      end
      if (e_chsk[s]) m_ptr[s] = e_id[s];
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic crdy, input logic rvld);
    c_vld  = v;
    c_crdy = crdy;
    c_rvld = rvld;
    c_rrdy = 4'hF;
  endtask

  int seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0;
    drive(4'h0, 1'b0, 1'b0);
    c_read  = 4'b0101;
    c_usr   = 4'b0011;
    c_rerr  = 1'b0;
    c_rusr  = 1'b1;
    c_rdata = 64'h0123_4567_89ab_cdef;
    for (int p = 0; p < N; p++) begin
      c_addr[p*32 +: 32]  = 32'h1000_0000 + 32'(p) * 32'h10;
      c_wdata[p*64 +: 64] = {32'hdead_0000 + 32'(p), 32'hbeef_0000 + 32'(p)};
      c_wmask[p*8 +: 8]   = 8'h0F << p;
    end
    mreset();

    // Reset state with idle inputs.
    eval();
    @(posedge clk);
    #1;
    rst = 1'b1;
    eval();
    tick();

    // Round-robin rotation with zero-cycle responses every cycle.
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 1'b1, 1'b1);
      eval();
      chk(1, "rr_rotation", 64'(d_gnt[1]), 64'(seq[i]));
      chk(0, "fp_lowest", 64'(d_gnt[0]), 64'd0);
      tick();
    end

    // Fixed priority: port 1 starves port 3 until it drops.
    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, 1'b1, 1'b1);
      eval();
      chk(0, "fp_port1_wins", 64'(d_gnt[0]), 64'd1);
      tick();
    end
    drive(4'b1000, 1'b1, 1'b1);
    eval();
    chk(0, "fp_port3_after_drop", 64'(d_gnt[0]), 64'd3);
    tick();

    // Grant lock on a stalled command from port 2.
    drive(4'b0100, 1'b0, 1'b0);
    eval();
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(4'b0101, 1'b0, 1'b0);
      eval();
      chk(0, "lock_hold", 64'(d_gnt[0]), 64'd2);
      chk(1, "lock_hold", 64'(d_gnt[1]), 64'd2);
      tick();
    end
    drive(4'b0101, 1'b1, 1'b0);
    eval();
    chk(0, "lock_hsk", 64'(d_gnt[0]), 64'd2);
    chk(1, "lock_hsk", 64'(d_gnt[1]), 64'd2);
    tick();
    drive(4'b1001, 1'b1, 1'b0);
    eval();
    chk(0, "after_lock", 64'(d_gnt[0]), 64'd0);
    chk(1, "after_lock", 64'(d_gnt[1]), 64'd3);
    tick();

    // FIFO full blocks commands; a pop frees the slot only from the next cycle.
    drive(4'b1001, 1'b1, 1'b0);
    eval();
    for (int s = 0; s < 2; s++) begin
      chk(s, "full_outstanding", 64'(d_out[s]), 64'd2);
      chk(s, "full_cmd_vld", 64'(d_cvld[s]), 64'd0);
      chk(s, "full_cmd_rdy", 64'(d_cmd_rdy[s]), 64'd0);
    end
    tick();
    drive(4'b1001, 1'b1, 1'b1);
    eval();
    for (int s = 0; s < 2; s++) begin
      chk(s, "pop_route", 64'(d_rsp_vld[s]), 64'b0100);
      chk(s, "pop_bubble", 64'(d_cvld[s]), 64'd0);
    end
    tick();
    drive(4'b1001, 1'b1, 1'b0);
    eval();
    for (int s = 0; s < 2; s++) chk(s, "resume", 64'(d_cvld[s]), 64'd1);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    eval();
    for (int s = 0; s < 2; s++) chk(s, "refilled", 64'(d_out[s]), 64'd2);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 1'b0, 1'b1);
      eval();
      tick();
    end

    // Zero-cycle bypass for port 1.
    drive(4'b0010, 1'b1, 1'b1);
    eval();
    for (int s = 0; s < 2; s++) chk(s, "bypass_rsp_vld", 64'(d_rsp_vld[s]), 64'b0010);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    eval();
    for (int s = 0; s < 2; s++) chk(s, "bypass_no_push", 64'(d_out[s]), 64'd0);
    tick();

    // Asynchronous reset with two commands outstanding.
    drive(4'b0001, 1'b1, 1'b0);
    eval();
    tick();
    drive(4'b0010, 1'b1, 1'b0);
    eval();
    tick();
    drive(4'b1111, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) chk(s, "async_rst_outstanding", 64'(d_out[s]), 64'd0);
    mreset();
    eval();
    @(posedge clk);
    #1;
    rst = 1'b1;
    eval();
    chk(1, "post_rst_grant", 64'(d_gnt[1]), 64'd0);
    tick();

    // Random traffic; command requests are held until the round-robin
    // instance accepts them.
    for (int p = 0; p < N; p++) pend[p] = c_vld[p];
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (e_chsk[1] && e_id[1] == p) pend[p] = 1'b0;
        if (!pend[p] && ($urandom_range(2) == 0)) begin
          pend[p] = 1'b1;
          c_read[p]           = 1'($urandom);
          c_usr[p]            = 1'($urandom);
          c_addr[p*32 +: 32]  = $urandom;
          c_wdata[p*64 +: 64] = {$urandom, $urandom};
          c_wmask[p*8 +: 8]   = 8'($urandom);
        end
        c_vld[p] = pend[p];
      end
      c_crdy  = ($urandom_range(3) != 0);
      c_rvld  = 1'($urandom);
      c_rrdy  = 4'($urandom) | 4'($urandom);
      c_rerr  = 1'($urandom);
      c_rusr  = 1'($urandom);
      c_rdata = {$urandom, $urandom};
      eval();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
